// File: rtl/challenge_res_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : challenge_res_drain_if
// Description : Bus bundle for the credit-gated result drain. Groups the
//               upstream source handshake, the pipeline issue/return
//               signals, the downstream valid/ready port and the status
//               counters/error flags.
//   master : environment side (source, pipeline, downstream consumer)
//   slave  : challenge_res_drain side
// Revision    : 1.0 - initial release
// ============================================================================
interface challenge_res_drain_if #(
  parameter int DEPTH = 16,
  parameter int FLEN  = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            src_vld;
  logic            src_rdy;
  logic            arg_vld;
  logic            res_vld;
  logic [FLEN-1:0] res;
  logic            out_vld;
  logic            out_rdy;
  logic [FLEN-1:0] out_data;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   occupancy;
  logic            ovf_err;
  logic            unexp_err;
  logic            lat_err;

  modport master (
    output src_vld, res_vld, res, out_rdy,
    input  src_rdy, arg_vld, out_vld, out_data, inflight, occupancy,
           ovf_err, unexp_err, lat_err
  );

  modport slave (
    input  src_vld, res_vld, res, out_rdy,
    output src_rdy, arg_vld, out_vld, out_data, inflight, occupancy,
           ovf_err, unexp_err, lat_err
  );
endinterface
`default_nettype wire

// File: rtl/challenge_res_drain.sv
`default_nettype none
// ============================================================================
// Module      : challenge_res_drain
// Description : Credit-gated result drain for the non-stallable
//               a**5 + 0.3*b + c pipeline. Issues argument sets only while
//               inflight + occupancy < DEPTH, captures pipeline results into
//               a first-word-fall-through FIFO and presents them with a
//               valid/ready handshake.
// Ports       : clk, rst (sync, active high)
//               bus (challenge_res_drain_if.slave):
//                 src_vld/src_rdy  upstream credit handshake
//                 arg_vld          issue strobe to the pipeline
//                 res_vld/res      pipeline result return
//                 out_vld/out_rdy/out_data  downstream FIFO head
//                 inflight, occupancy       credit counters
//                 ovf_err, unexp_err, lat_err  sticky error flags
// Options     : RES_DRAIN_LAT_CHECK_EN - builds a LAT-deep issue shift
//               register that flags any res_vld not matching issue timing.
// Revision    : 1.0 - initial release
// ============================================================================
module challenge_res_drain #(
  parameter int DEPTH = 16,
  parameter int LAT   = 14,
  parameter int FLEN  = 32   // stands in for the codebase global FLEN
) (
  input wire clk,
  input wire rst,
  challenge_res_drain_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            unexp_q, unexp_d;
  logic [FLEN-1:0] mem_q [DEPTH];

  logic [CW:0] credit_used;
  logic        src_rdy, issue, ret, wr, pop, out_vld;

  // One extra bit so the sum of two full counters cannot wrap.
  assign credit_used = {1'b0, inflight_q} + {1'b0, occ_q};
  assign src_rdy     = !rst && (credit_used < (CW+1)'(DEPTH));
  assign issue       = bus.src_vld && src_rdy;
  assign ret         = bus.res_vld;
  assign wr          = ret && (occ_q < CW'(DEPTH));
  assign out_vld     = (occ_q != '0);
  assign pop         = out_vld && bus.out_rdy;

  always_comb begin
    inflight_d = inflight_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q | (ret && !wr);
    unexp_d    = unexp_q | (ret && (inflight_q == '0));

    // Issue and return together cancel; a return with nothing in flight
    // cannot drive the counter below zero.
    if (issue && !ret) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!issue && ret && (inflight_q != '0)) begin
      inflight_d = inflight_q - CW'(1);
    end

    if (wr && !pop) begin
      occ_d = occ_q + CW'(1);
    end else if (!wr && pop) begin
      occ_d = occ_q - CW'(1);
    end

    if (wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      unexp_q    <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      unexp_q    <= unexp_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= bus.res;
    end
  end

`ifdef RES_DRAIN_LAT_CHECK_EN
  logic [LAT-1:0] lat_sr_q, lat_sr_d;
  logic           lat_q, lat_d;

  // Bit k holds the issue strobe from k+1 cycles ago, so the MSB is the
  // issue that must be returning in the current cycle.
  always_comb begin
    lat_sr_d = (lat_sr_q << 1) | LAT'(issue);
    lat_d    = lat_q | (lat_sr_q[LAT-1] != ret);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_sr_q <= '0;
      lat_q    <= 1'b0;
    end else begin
      lat_sr_q <= lat_sr_d;
      lat_q    <= lat_d;
    end
  end

  assign bus.lat_err = lat_q;
`else
  // Without the checker the flag is constant 0 for every legal LAT.
  assign bus.lat_err = (LAT < 1);
`endif

  assign bus.src_rdy   = src_rdy;
  assign bus.arg_vld   = issue;
  assign bus.out_vld   = out_vld;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.inflight  = inflight_q;
  assign bus.occupancy = occ_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.unexp_err = unexp_q;
endmodule
`default_nettype wire

// File: tb/tb_challenge_res_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_challenge_res_drain
// Description : Self-checking bench for challenge_res_drain. A queue-based
//               model (credit count, FIFO contents, pipeline delay line,
//               sticky flags) is compared with the DUT every cycle, and a
//               few directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_challenge_res_drain;
  localparam int DEPTH = 16;
  localparam int LAT   = 14;
  localparam int FLEN  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  challenge_res_drain_if #(.DEPTH(DEPTH), .FLEN(FLEN)) ifc ();

  challenge_res_drain #(.DEPTH(DEPTH), .LAT(LAT), .FLEN(FLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int plat   = LAT;
  bit mv     = 1'b0;

  // behavioural model state
  logic [FLEN-1:0] fifo[$];
  int              m_infl = 0;
  bit              m_ovf = 0, m_unexp = 0, m_lat = 0;
  bit              ih [64];
  int              due_q[$];
  logic [FLEN-1:0] dat_q[$];

  // snapshot of DUT outputs seen in the most recent step
  int s_occ, s_infl;
  bit s_rdy, s_ov, s_ovf, s_unexp, s_lat;
  int n_iss, n_pop, fi, fo;

  function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  task automatic step(input bit r, input bit sv, input bit ordy,
                      input bit fr = 1'b0, input logic [FLEN-1:0] fd = '0);
    bit pv, rv, m_rdy, iss, pop, wr, exp_bit;
    logic [FLEN-1:0] rd;
    @(negedge clk);
    pv = !r && (due_q.size() > 0) && (due_q[0] == cyc);
    rv = pv || (fr && !r);
    rd = pv ? dat_q[0] : (fr ? fd : FLEN'($urandom));
    rst         = r;
    ifc.src_vld = sv;
    ifc.out_rdy = ordy;
    ifc.res_vld = rv;
    ifc.res     = rd;
    #1;
    m_rdy = !r && ((m_infl + fifo.size()) < DEPTH);
    iss   = sv && m_rdy;

    s_occ = int'(ifc.occupancy); s_infl = int'(ifc.inflight);
    s_rdy = ifc.src_rdy; s_ov = ifc.out_vld; s_ovf = ifc.ovf_err;
    s_unexp = ifc.unexp_err; s_lat = ifc.lat_err;
    if (ifc.arg_vld) n_iss++;
    if (ifc.out_vld && ordy) n_pop++;
    if (fi < 0 && ifc.arg_vld) fi = cyc;
    if (fo < 0 && ifc.out_vld) fo = cyc;

    if (mv) begin
      chk("src_rdy",   ifc.src_rdy,   m_rdy);
      chk("arg_vld",   ifc.arg_vld,   iss);
      chk("out_vld",   ifc.out_vld,   fifo.size() != 0);
      if (fifo.size() != 0) chk("out_data", ifc.out_data, fifo[0]);
      chk("inflight",  ifc.inflight,  m_infl);
      chk("occupancy", ifc.occupancy, fifo.size());
      chk("ovf_err",   ifc.ovf_err,   m_ovf);
      chk("unexp_err", ifc.unexp_err, m_unexp);
      chk("lat_err",   ifc.lat_err,   m_lat);
    end

    if (r) begin
      fifo.delete(); due_q.delete(); dat_q.delete();
      m_infl = 0; m_ovf = 0; m_unexp = 0; m_lat = 0;
      foreach (ih[i]) ih[i] = 1'b0;
      mv = 1'b1;
    end else begin
      if (pv) begin
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      exp_bit = (cyc >= LAT) ? ih[(cyc - LAT) % 64] : 1'b0;
`ifdef RES_DRAIN_LAT_CHECK_EN
      if (exp_bit != rv) m_lat = 1'b1;
`endif
      ih[cyc % 64] = iss;
      if (rv && m_infl == 0) m_unexp = 1'b1;
      if (iss && !rv) m_infl++;
      else if (!iss && rv && m_infl > 0) m_infl--;
      pop = (fifo.size() > 0) && ordy;
      wr  = rv && (fifo.size() < DEPTH);
      if (rv && !wr) m_ovf = 1'b1;
      if (pop) void'(fifo.pop_front());
      if (wr) fifo.push_back(rd);
      if (iss) begin
        due_q.push_back(cyc + plat);
        dat_q.push_back(FLEN'($urandom));
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_iss = 0; n_pop = 0; fi = -1; fo = -1;
  endtask

  initial begin
    ifc.src_vld = 1'b0; ifc.out_rdy = 1'b0; ifc.res_vld = 1'b0; ifc.res = '0;

    // streaming at full rate
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    chk("rst_occupancy", s_occ, 0);
    chk("rst_src_rdy", s_rdy, 1);
    fi = -1; fo = -1; n_iss = 0; n_pop = 0;
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1);
    chk("stream_issues", n_iss, 200);
    chk("stream_pops", n_pop, 200);
    chk("stream_first_out", fo - fi, 15);
    chk("stream_end_occ", s_occ, 0);

    // full stall, overflow injection, drain
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);
    chk("stall_issues", n_iss, 16);
    chk("stall_occ", s_occ, 16);
    chk("stall_inflight", s_infl, 0);
    chk("stall_rdy", s_rdy, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0);
    chk("ovf_flag", s_ovf, 1);
    chk("ovf_occ", s_occ, 16);
    step(1'b0, 1'b1, 1'b1);
    chk("first_pop_rdy", s_rdy, 0);
    step(1'b0, 1'b1, 1'b1);
    chk("rdy_after_pop", s_rdy, 1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);

    // unexpected result
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234);
    step(1'b0, 1'b0, 1'b0);
    chk("unexp_flag", s_unexp, 1);
    chk("unexp_occ", s_occ, 1);
    chk("unexp_inflight", s_infl, 0);
    step(1'b0, 1'b0, 1'b1);

    // reset with traffic in flight
    do_reset();
    for (int i = 0; i < 21; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_occ", s_occ, 7);
    chk("mid_inflight", s_infl, 9);
    step(1'b0, 1'b1, 1'b0);
    chk("post_rst_occ", s_occ, 0);
    chk("post_rst_inflight", s_infl, 0);
    chk("post_rst_out_vld", s_ov, 0);
    chk("post_rst_ovf", s_ovf, 0);
    chk("post_rst_unexp", s_unexp, 0);
    chk("post_rst_rdy", s_rdy, 1);

    // wrong pipeline latency
    do_reset();
    plat = 15;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
`ifdef RES_DRAIN_LAT_CHECK_EN
    chk("lat_err_set", s_lat, 1);
`else
    chk("lat_err_off", s_lat, 0);
`endif
    plat = LAT;

    // randomized traffic with varying back-pressure
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      int bias;
      bias = int'($urandom_range(1, 3));
      for (int i = 0; i < 500; i++)
        step(1'b0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)) < bias);
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);
    chk("rand_end_occ", s_occ, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
